// File: rtl/rx_frame_buffer_widen.sv
// rtl/rx_frame_buffer_widen.sv - Ethernet RX frame ring: 8-bit MAC writes, 64-bit CPU reads.
module rx_frame_buffer_widen #(
  parameter int NBUF  = 2,
  parameter int DEPTH = 2048,
  localparam int AW   = $clog2(DEPTH/8)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic          rx_sof,
  input  logic          rx_last,
  input  logic          rx_err,
  output logic          frame_avail,
  output logic [11:0]   frame_len,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [63:0]   rd_data,
  input  logic          frame_release,
  output logic [15:0]   drop_cnt
);

  localparam int HW    = $clog2(NBUF);
  localparam int CW    = $clog2(NBUF) + 1;
  localparam int BW    = $clog2(DEPTH);
  localparam int LW    = BW + 1;
  localparam int WORDS = NBUF * DEPTH / 8;

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  state_t        state, state_n;
  logic [HW-1:0] head, tail;
  logic [CW-1:0] full_cnt;
  logic [LW-1:0] wr_ptr, wr_ptr_n;
  logic [11:0]   len_q [NBUF];
  logic [63:0]   mem [WORDS];

  logic          we;
  logic [BW-1:0] wbyte;
  logic          commit;
  logic [11:0]   commit_len;
  logic [1:0]    drop_add;
  logic          sof_path;
  logic          start;
  logic          finish;
  logic          release_ok;
  logic [16:0]   drop_sum;

  assign frame_avail = (full_cnt != '0);
  assign frame_len   = len_q[head];
  assign release_ok  = frame_release & frame_avail;
  assign drop_sum    = {1'b0, drop_cnt} + {15'd0, drop_add};

  // sof_path funnels IDLE starts and DROP-state restarts through one free-slot check;
  // a restart from RECV reuses the slot it already owns and skips that check.
  always_comb begin
    state_n    = state;
    wr_ptr_n   = wr_ptr;
    we         = 1'b0;
    wbyte      = '0;
    commit     = 1'b0;
    commit_len = '0;
    drop_add   = 2'd0;
    sof_path   = 1'b0;
    start      = 1'b0;
    finish     = 1'b0;
    if (rx_valid) begin
      case (state)
        IDLE: sof_path = rx_sof;
        RECV: begin
          if (rx_sof) begin
            drop_add = 2'd1;
            start    = 1'b1;
          end else if (wr_ptr == LW'(DEPTH)) begin
            if (rx_last) begin
              drop_add = 2'd1;
              state_n  = IDLE;
            end else begin
              state_n  = DROP;
            end
          end else begin
            we    = 1'b1;
            wbyte = wr_ptr[BW-1:0];
            if (rx_last) finish = 1'b1;
            else         wr_ptr_n = wr_ptr + 1'b1;
          end
        end
        DROP: begin
          if (rx_sof) begin
            drop_add = 2'd1;
            sof_path = 1'b1;
          end else if (rx_last) begin
            drop_add = 2'd1;
            state_n  = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase

      if (sof_path) begin
        if (full_cnt == CW'(NBUF)) begin
          if (rx_last) begin
            drop_add = drop_add + 2'd1;
            state_n  = IDLE;
          end else begin
            state_n  = DROP;
          end
        end else begin
          start = 1'b1;
        end
      end

      if (start) begin
        we    = 1'b1;
        wbyte = '0;
        if (rx_last) begin
          finish = 1'b1;
        end else begin
          wr_ptr_n = LW'(1);
          state_n  = RECV;
        end
      end

      if (finish) begin
        state_n = IDLE;
        if (rx_err) begin
          drop_add = drop_add + 2'd1;
        end else begin
          commit     = 1'b1;
          commit_len = start ? 12'd1 : 12'(wr_ptr) + 12'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      head     <= '0;
      tail     <= '0;
      full_cnt <= '0;
      wr_ptr   <= '0;
      drop_cnt <= '0;
      rd_data  <= '0;
      for (int i = 0; i < NBUF; i++) len_q[i] <= '0;
    end else begin
      state  <= state_n;
      wr_ptr <= wr_ptr_n;
      if (commit) begin
        len_q[tail] <= commit_len;
        tail        <= tail + 1'b1;
      end
      if (release_ok) head <= head + 1'b1;
      case ({commit, release_ok})
        2'b10:   full_cnt <= full_cnt + 1'b1;
        2'b01:   full_cnt <= full_cnt - 1'b1;
        default: full_cnt <= full_cnt;
      endcase
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (rd_en) rd_data <= mem[{head, rd_addr}];
    end
  end

  always_ff @(posedge clk) begin
    if (we && !rst) mem[{tail, wbyte[BW-1:3]}][{wbyte[2:0], 3'b000} +: 8] <= rx_data;
  end

endmodule
